// File: rtl/stream_pkg.sv
// Shared definitions for the stream demultiplexer: FSM encoding, statistics
// counter width and select-token sizing.
package stream_pkg;

  localparam int unsigned STATS_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    DROP
  } demux_state_t;

  // A select token is at least one bit wide even for degenerate stream counts.
  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/data_demux_out_reg.sv
// One-entry output buffer of the demultiplexer: holds a beat plus its destination
// tag, decodes the per-port valids and drains on the destination's ready.
module data_demux_out_reg #(
  parameter type         data_t       = logic [7:0],
  parameter int unsigned NUM_ELEMENTS = 8,
  parameter int unsigned NUM_STREAMS  = 4,
  parameter int unsigned SEL_W        = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    load,
  input  logic [SEL_W-1:0]                        load_dest,
  input  data_t [NUM_ELEMENTS-1:0]                load_data,
  input  logic [NUM_ELEMENTS-1:0]                 load_keep,
  input  logic                                    load_last,
  input  logic [NUM_STREAMS-1:0]                  out_ready,
  output logic                                    buf_valid,
  output logic                                    dest_ready,
  output logic [NUM_STREAMS-1:0]                  out_valid,
  output data_t [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0] out_data,
  output logic [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0] out_keep,
  output logic [NUM_STREAMS-1:0]                  out_last
);

  logic [SEL_W-1:0]         buf_dest;
  data_t [NUM_ELEMENTS-1:0] buf_data;
  logic [NUM_ELEMENTS-1:0]  buf_keep;
  logic                     buf_last;

  // A load in the same cycle as a drain wins, so the buffer stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
    end else if (buf_valid && dest_ready) begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      buf_dest <= load_dest;
      buf_data <= load_data;
      buf_keep <= load_keep;
      buf_last <= load_last;
    end
  end

  always_comb begin
    dest_ready = 1'b0;
    out_valid  = '0;
    out_data   = '0;
    out_keep   = '0;
    out_last   = '0;
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      if (buf_dest == SEL_W'(i)) begin
        dest_ready   = out_ready[i];
        out_valid[i] = buf_valid;
      end
      out_data[i] = buf_data;
      out_keep[i] = buf_keep;
      out_last[i] = buf_last;
    end
  end

endmodule

// File: rtl/data_demultiplexer.sv
// Routes one packet stream to NUM_STREAMS outputs, one packet per select token,
// through a registered output stage. Define DATA_DEMULTIPLEXER_STATS_EN for counters.
module data_demultiplexer
  import stream_pkg::*;
#(
  parameter type         data_t       = logic [7:0],
  parameter int unsigned NUM_ELEMENTS = 8,
  parameter int unsigned NUM_STREAMS  = 4,
  localparam int unsigned SEL_W       = sel_width(NUM_STREAMS)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    select_valid,
  output logic                                    select_ready,
  input  logic [SEL_W-1:0]                        select_data,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  data_t [NUM_ELEMENTS-1:0]                in_data,
  input  logic [NUM_ELEMENTS-1:0]                 in_keep,
  input  logic                                    in_last,
  output logic [NUM_STREAMS-1:0]                  out_valid,
  input  logic [NUM_STREAMS-1:0]                  out_ready,
  output data_t [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0] out_data,
  output logic [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0] out_keep,
  output logic [NUM_STREAMS-1:0]                  out_last
`ifdef DATA_DEMULTIPLEXER_STATS_EN
  ,
  output logic [NUM_STREAMS-1:0][STATS_CNT_W-1:0] pkt_count,
  output logic [STATS_CNT_W-1:0]                  drop_count
`endif
);

  demux_state_t     state_q, state_d;
  logic [SEL_W-1:0] sel_q;
  logic             sel_in_range;
  logic             load;
  logic             buf_valid;
  logic             dest_ready;

  assign sel_in_range = ({1'b0, select_data} < (SEL_W + 1)'(NUM_STREAMS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (select_valid && select_ready) begin
      sel_q <= select_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (select_valid) state_d = sel_in_range ? ROUTE : DROP;
      ROUTE:   if (in_valid && in_ready && in_last) state_d = IDLE;
      DROP:    if (in_valid && in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Input gating follows the buffered beat's destination, not the new token.
  always_comb begin
    select_ready = 1'b0;
    in_ready     = 1'b0;
    load         = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:  select_ready = 1'b1;
        ROUTE: begin
          in_ready = !buf_valid || dest_ready;
          load     = in_valid && (!buf_valid || dest_ready);
        end
        DROP:  in_ready = 1'b1;
        default: ;
      endcase
    end
  end

  data_demux_out_reg #(
    .data_t       (data_t),
    .NUM_ELEMENTS (NUM_ELEMENTS),
    .NUM_STREAMS  (NUM_STREAMS),
    .SEL_W        (SEL_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_dest  (sel_q),
    .load_data  (in_data),
    .load_keep  (in_keep),
    .load_last  (in_last),
    .out_ready  (out_ready),
    .buf_valid  (buf_valid),
    .dest_ready (dest_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_last   (out_last)
  );

`ifdef DATA_DEMULTIPLEXER_STATS_EN
  logic [STATS_CNT_W-1:0] pkt_q [NUM_STREAMS];
  logic [STATS_CNT_W-1:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
        pkt_q[i] <= '0;
      end
      drop_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
        pkt_q[i] <= pkt_q[i] + STATS_CNT_W'(out_valid[i] && out_ready[i] && out_last[i]);
      end
      drop_q <= drop_q + STATS_CNT_W'(state_q == DROP && in_valid && in_last);
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      pkt_count[i] = pkt_q[i];
    end
    drop_count = drop_q;
  end
`endif

endmodule

// File: tb/tb_data_demultiplexer.sv
// Directed bench for data_demultiplexer: routing, bubbles, back-pressure, drop,
// reset mid-packet and (with DATA_DEMULTIPLEXER_STATS_EN) the packet counters.
module tb_data_demultiplexer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Four-stream DUT
  logic                 sel_valid = 1'b0;
  logic [1:0]           sel_data = 2'd0;
  logic                 sel_ready;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [7:0][7:0]      in_data = '0;
  logic [7:0]           in_keep = 8'hFF;
  logic                 in_last = 1'b0;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready = 4'hF;
  logic [3:0][7:0][7:0] out_data;
  logic [3:0][7:0]      out_keep;
  logic [3:0]           out_last;

  // Three-stream DUT (has out-of-range tokens)
  logic                 s3_sel_valid = 1'b0;
  logic [1:0]           s3_sel_data = 2'd0;
  logic                 s3_sel_ready;
  logic                 s3_in_valid = 1'b0;
  logic                 s3_in_ready;
  logic [7:0][7:0]      s3_in_data = '0;
  logic [7:0]           s3_in_keep = 8'hFF;
  logic                 s3_in_last = 1'b0;
  logic [2:0]           s3_out_valid;
  logic [2:0]           s3_out_ready = 3'h7;
  logic [2:0][7:0][7:0] s3_out_data;
  logic [2:0][7:0]      s3_out_keep;
  logic [2:0]           s3_out_last;

`ifdef DATA_DEMULTIPLEXER_STATS_EN
  logic [3:0][31:0] pkt_count;
  logic [31:0]      drop_count;
  logic [2:0][31:0] s3_pkt_count;
  logic [31:0]      s3_drop_count;
`endif

  data_demultiplexer #(.NUM_ELEMENTS(8), .NUM_STREAMS(4)) dut (
    .clk(clk), .rst(rst),
    .select_valid(sel_valid), .select_ready(sel_ready), .select_data(sel_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last)
`ifdef DATA_DEMULTIPLEXER_STATS_EN
    , .pkt_count(pkt_count), .drop_count(drop_count)
`endif
  );

  data_demultiplexer #(.NUM_ELEMENTS(8), .NUM_STREAMS(3)) dut3 (
    .clk(clk), .rst(rst),
    .select_valid(s3_sel_valid), .select_ready(s3_sel_ready), .select_data(s3_sel_data),
    .in_valid(s3_in_valid), .in_ready(s3_in_ready), .in_data(s3_in_data),
    .in_keep(s3_in_keep), .in_last(s3_in_last),
    .out_valid(s3_out_valid), .out_ready(s3_out_ready), .out_data(s3_out_data),
    .out_keep(s3_out_keep), .out_last(s3_out_last)
`ifdef DATA_DEMULTIPLEXER_STATS_EN
    , .pkt_count(s3_pkt_count), .drop_count(s3_drop_count)
`endif
  );

  // One cycle of stimulus and the outputs expected at the following negedge.
  typedef struct packed {
    logic       sv;
    logic [1:0] sd;
    logic       iv;
    logic [7:0] id;
    logic       il;
    logic [7:0] ik;
    logic [3:0] ordy;
    logic [3:0] ov;
    logic [7:0] oid;
    logic       ol;
    logic [7:0] ok;
    logic       srdy;
    logic       irdy;
  } row_t;

  row_t tab_route [7] = '{
    '{1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'b0000, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0},
    '{1'b0, 2'd0, 1'b1, 8'h10, 1'b0, 8'hFF, 4'hF, 4'b0000, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1},
    '{1'b0, 2'd0, 1'b1, 8'h11, 1'b0, 8'hFF, 4'hF, 4'b0100, 8'h10, 1'b0, 8'hFF, 1'b0, 1'b1},
    '{1'b0, 2'd0, 1'b1, 8'h12, 1'b0, 8'hFF, 4'hF, 4'b0100, 8'h11, 1'b0, 8'hFF, 1'b0, 1'b1},
    '{1'b0, 2'd0, 1'b1, 8'h13, 1'b1, 8'hFF, 4'hF, 4'b0100, 8'h12, 1'b0, 8'hFF, 1'b0, 1'b1},
    '{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'b0100, 8'h13, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'b0000, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0}
  };

  row_t tab_b2b [11] = '{
    '{1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'b0000, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0},
    '{1'b0, 2'd0, 1'b1, 8'h20, 1'b0, 8'hFF, 4'hF, 4'b0000, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1},
    '{1'b0, 2'd0, 1'b1, 8'h21, 1'b0, 8'hFF, 4'hF, 4'b0001, 8'h20, 1'b0, 8'hFF, 1'b0, 1'b1},
    '{1'b0, 2'd0, 1'b1, 8'h22, 1'b1, 8'hFF, 4'hF, 4'b0001, 8'h21, 1'b0, 8'hFF, 1'b0, 1'b1},
    '{1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'b0001, 8'h22, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{1'b0, 2'd0, 1'b1, 8'h30, 1'b1, 8'h00, 4'hF, 4'b0000, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1},
    '{1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'b0010, 8'h30, 1'b1, 8'h00, 1'b1, 1'b0},
    '{1'b0, 2'd0, 1'b1, 8'h40, 1'b0, 8'hFF, 4'hF, 4'b0000, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1},
    '{1'b0, 2'd0, 1'b1, 8'h41, 1'b1, 8'hFF, 4'hF, 4'b0001, 8'h40, 1'b0, 8'hFF, 1'b0, 1'b1},
    '{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'b0001, 8'h41, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'b0000, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0}
  };

  row_t tab_bp [11] = '{
    '{1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF,    4'b0000, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0},
    '{1'b0, 2'd0, 1'b1, 8'h50, 1'b1, 8'hFF, 4'b1101, 4'b0000, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1},
    '{1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 8'hFF, 4'b1101, 4'b0010, 8'h50, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{1'b0, 2'd0, 1'b1, 8'h60, 1'b0, 8'hFF, 4'b1101, 4'b0010, 8'h50, 1'b1, 8'hFF, 1'b0, 1'b0},
    '{1'b0, 2'd0, 1'b1, 8'h60, 1'b0, 8'hFF, 4'b1101, 4'b0010, 8'h50, 1'b1, 8'hFF, 1'b0, 1'b0},
    '{1'b0, 2'd0, 1'b1, 8'h60, 1'b0, 8'hFF, 4'b1101, 4'b0010, 8'h50, 1'b1, 8'hFF, 1'b0, 1'b0},
    '{1'b0, 2'd0, 1'b1, 8'h60, 1'b0, 8'hFF, 4'b1101, 4'b0010, 8'h50, 1'b1, 8'hFF, 1'b0, 1'b0},
    '{1'b0, 2'd0, 1'b1, 8'h60, 1'b0, 8'hFF, 4'hF,    4'b0010, 8'h50, 1'b1, 8'hFF, 1'b0, 1'b1},
    '{1'b0, 2'd0, 1'b1, 8'h61, 1'b1, 8'hFF, 4'hF,    4'b1000, 8'h60, 1'b0, 8'hFF, 1'b0, 1'b1},
    '{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF,    4'b1000, 8'h61, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF,    4'b0000, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0}
  };

  function automatic logic [63:0] word(input logic [7:0] id);
    return {8{id}} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic int unsigned port_of(input logic [3:0] v);
    for (int unsigned i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic drive(input row_t r);
    @(negedge clk);
    sel_valid = r.sv;
    sel_data  = r.sd;
    in_valid  = r.iv;
    in_data   = word(r.id);
    in_last   = r.il;
    in_keep   = r.ik;
    out_ready = r.ordy;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    n_cmp++; if (sel_ready !== 1'b0) begin n_bad++; $display("FAIL reset_sel_ready got %b exp 0", sel_ready); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0000", out_valid); end
    n_cmp++; if (s3_out_valid !== 3'b000) begin n_bad++; $display("FAIL reset_s3_out_valid got %b exp 000", s3_out_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (sel_ready !== 1'b1) begin n_bad++; $display("FAIL idle_sel_ready got %b exp 1", sel_ready); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL idle_out_valid got %b exp 0000", out_valid); end
  endtask

  task automatic test_route;
    int unsigned d;
    for (int i = 0; i < $size(tab_route); i++) begin
      drive(tab_route[i]);
      n_cmp++; if (out_valid !== tab_route[i].ov) begin n_bad++; $display("FAIL route[%0d] out_valid got %b exp %b", i, out_valid, tab_route[i].ov); end
      n_cmp++; if (sel_ready !== tab_route[i].srdy) begin n_bad++; $display("FAIL route[%0d] select_ready got %b exp %b", i, sel_ready, tab_route[i].srdy); end
      n_cmp++; if (in_ready !== tab_route[i].irdy) begin n_bad++; $display("FAIL route[%0d] in_ready got %b exp %b", i, in_ready, tab_route[i].irdy); end
      if (tab_route[i].ov != 4'b0000) begin
        d = port_of(tab_route[i].ov);
        n_cmp++;
        if (out_data[d] !== word(tab_route[i].oid) || out_last[d] !== tab_route[i].ol || out_keep[d] !== tab_route[i].ok) begin
          n_bad++;
          $display("FAIL route[%0d] beat got %h/%b/%h exp %h/%b/%h", i, out_data[d], out_last[d], out_keep[d],
                   word(tab_route[i].oid), tab_route[i].ol, tab_route[i].ok);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int unsigned d;
    for (int i = 0; i < $size(tab_b2b); i++) begin
      drive(tab_b2b[i]);
      n_cmp++; if (out_valid !== tab_b2b[i].ov) begin n_bad++; $display("FAIL b2b[%0d] out_valid got %b exp %b", i, out_valid, tab_b2b[i].ov); end
      n_cmp++; if (sel_ready !== tab_b2b[i].srdy) begin n_bad++; $display("FAIL b2b[%0d] select_ready got %b exp %b", i, sel_ready, tab_b2b[i].srdy); end
      n_cmp++; if (in_ready !== tab_b2b[i].irdy) begin n_bad++; $display("FAIL b2b[%0d] in_ready got %b exp %b", i, in_ready, tab_b2b[i].irdy); end
      if (tab_b2b[i].ov != 4'b0000) begin
        d = port_of(tab_b2b[i].ov);
        n_cmp++;
        if (out_data[d] !== word(tab_b2b[i].oid) || out_last[d] !== tab_b2b[i].ol || out_keep[d] !== tab_b2b[i].ok) begin
          n_bad++;
          $display("FAIL b2b[%0d] beat got %h/%b/%h exp %h/%b/%h", i, out_data[d], out_last[d], out_keep[d],
                   word(tab_b2b[i].oid), tab_b2b[i].ol, tab_b2b[i].ok);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int unsigned d;
    for (int i = 0; i < $size(tab_bp); i++) begin
      drive(tab_bp[i]);
      n_cmp++; if (out_valid !== tab_bp[i].ov) begin n_bad++; $display("FAIL bp[%0d] out_valid got %b exp %b", i, out_valid, tab_bp[i].ov); end
      n_cmp++; if (sel_ready !== tab_bp[i].srdy) begin n_bad++; $display("FAIL bp[%0d] select_ready got %b exp %b", i, sel_ready, tab_bp[i].srdy); end
      n_cmp++; if (in_ready !== tab_bp[i].irdy) begin n_bad++; $display("FAIL bp[%0d] in_ready got %b exp %b", i, in_ready, tab_bp[i].irdy); end
      if (tab_bp[i].ov != 4'b0000) begin
        d = port_of(tab_bp[i].ov);
        n_cmp++;
        if (out_data[d] !== word(tab_bp[i].oid) || out_last[d] !== tab_bp[i].ol || out_keep[d] !== tab_bp[i].ok) begin
          n_bad++;
          $display("FAIL bp[%0d] beat got %h/%b/%h exp %h/%b/%h", i, out_data[d], out_last[d], out_keep[d],
                   word(tab_bp[i].oid), tab_bp[i].ol, tab_bp[i].ok);
        end
      end
    end
  endtask

  task automatic test_drop;
`ifdef DATA_DEMULTIPLEXER_STATS_EN
    n_cmp++; if (s3_drop_count !== 32'd0) begin n_bad++; $display("FAIL drop_count_before got %0d exp 0", s3_drop_count); end
`endif
    @(negedge clk);
    s3_sel_valid = 1'b1; s3_sel_data = 2'd3;
    #1;
    n_cmp++; if (s3_sel_ready !== 1'b1) begin n_bad++; $display("FAIL drop_sel_ready got %b exp 1", s3_sel_ready); end
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      s3_sel_valid = 1'b0;
      s3_in_valid  = 1'b1;
      s3_in_data   = word(8'(8'h70 + b));
      s3_in_last   = (b == 1);
      #1;
      n_cmp++; if (s3_in_ready !== 1'b1) begin n_bad++; $display("FAIL drop_in_ready[%0d] got %b exp 1", b, s3_in_ready); end
      n_cmp++; if (s3_out_valid !== 3'b000) begin n_bad++; $display("FAIL drop_out_valid[%0d] got %b exp 000", b, s3_out_valid); end
    end
    @(negedge clk);
    s3_in_valid = 1'b0; s3_in_last = 1'b0;
    #1;
    n_cmp++; if (s3_out_valid !== 3'b000) begin n_bad++; $display("FAIL drop_after_out_valid got %b exp 000", s3_out_valid); end
    n_cmp++; if (s3_sel_ready !== 1'b1) begin n_bad++; $display("FAIL drop_after_sel_ready got %b exp 1", s3_sel_ready); end
`ifdef DATA_DEMULTIPLEXER_STATS_EN
    n_cmp++; if (s3_drop_count !== 32'd1) begin n_bad++; $display("FAIL drop_count_after got %0d exp 1", s3_drop_count); end
`endif
    // The highest legal destination still routes after a drop.
    s3_sel_valid = 1'b1; s3_sel_data = 2'd2;
    @(negedge clk);
    s3_sel_valid = 1'b0;
    s3_in_valid = 1'b1; s3_in_data = word(8'h90); s3_in_last = 1'b1;
    #1;
    n_cmp++; if (s3_in_ready !== 1'b1) begin n_bad++; $display("FAIL s3_route_in_ready got %b exp 1", s3_in_ready); end
    @(negedge clk);
    s3_in_valid = 1'b0; s3_in_last = 1'b0;
    #1;
    n_cmp++; if (s3_out_valid !== 3'b100) begin n_bad++; $display("FAIL s3_route_out_valid got %b exp 100", s3_out_valid); end
    n_cmp++; if (s3_out_data[2] !== word(8'h90) || s3_out_last[2] !== 1'b1) begin
      n_bad++; $display("FAIL s3_route_beat got %h/%b exp %h/1", s3_out_data[2], s3_out_last[2], word(8'h90));
    end
  endtask

  task automatic test_reset_mid_packet;
    drive('{1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    drive('{1'b0, 2'd0, 1'b1, 8'h70, 1'b0, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    drive('{1'b0, 2'd0, 1'b1, 8'h71, 1'b0, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    drive('{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    n_cmp++; if (out_valid !== 4'b0001 || out_data[0] !== word(8'h71)) begin
      n_bad++; $display("FAIL midrst_buffered got %b/%h exp 0001/%h", out_valid, out_data[0], word(8'h71));
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (sel_ready !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready_in_rst got %b%b exp 00", sel_ready, in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL midrst_out_valid got %b exp 0000", out_valid); end
    n_cmp++; if (sel_ready !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_idle got %b%b exp 10", sel_ready, in_ready); end
    drive('{1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    drive('{1'b0, 2'd0, 1'b1, 8'h80, 1'b1, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    drive('{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    n_cmp++; if (out_valid !== 4'b0001 || out_data[0] !== word(8'h80) || out_last[0] !== 1'b1) begin
      n_bad++; $display("FAIL midrst_fresh got %b/%h/%b exp 0001/%h/1", out_valid, out_data[0], out_last[0], word(8'h80));
    end
    drive('{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL midrst_drained got %b exp 0000", out_valid); end
  endtask

`ifdef DATA_DEMULTIPLEXER_STATS_EN
  task automatic send_one(input logic [1:0] dest);
    drive('{1'b1, dest, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    drive('{1'b0, 2'd0, 1'b1, 8'hA0, 1'b1, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    drive('{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
  endtask

  task automatic test_stats;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    send_one(2'd0); send_one(2'd0); send_one(2'd2); send_one(2'd0);
    drive('{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    n_cmp++; if (pkt_count[0] !== 32'd3) begin n_bad++; $display("FAIL pkt_count0 got %0d exp 3", pkt_count[0]); end
    n_cmp++; if (pkt_count[1] !== 32'd0) begin n_bad++; $display("FAIL pkt_count1 got %0d exp 0", pkt_count[1]); end
    n_cmp++; if (pkt_count[2] !== 32'd1) begin n_bad++; $display("FAIL pkt_count2 got %0d exp 1", pkt_count[2]); end
    n_cmp++; if (pkt_count[3] !== 32'd0) begin n_bad++; $display("FAIL pkt_count3 got %0d exp 0", pkt_count[3]); end
    force dut.pkt_q[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.pkt_q[0];
    send_one(2'd0);
    drive('{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 4'hF, 4'h0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    n_cmp++; if (pkt_count[0] !== 32'd0) begin n_bad++; $display("FAIL pkt_count0_wrap got %0d exp 0", pkt_count[0]); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_route();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_reset_mid_packet();
`ifdef DATA_DEMULTIPLEXER_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
